// File: rtl/fpu_ss_scoreboard_mp.sv
// FPU subsystem scoreboard: per-register pending-write counters,
// commit tracking and issue gating for multiple writeback ports.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   issue_*              buffer-head instruction; fire = valid & ready
//   commit_*             commit/kill strobe per offload ID
//   wb_valid_i/addr_i    NUM_WB writeback ports, one retired write each
//   dep_rs_o/dep_rd_o    RAW hazard per source / rd counter saturated
//   fwd_valid_o/sel_o    source satisfied by same-cycle writeback
//   busy_o, err_o        any write pending / sticky underflow
//
// Optional feature: define FPU_SS_SB_FWD_EN for same-cycle forwarding.

module fpu_ss_scoreboard_mp #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned NUM_RS   = 3,
  parameter int unsigned NUM_WB   = 2,
  parameter int unsigned ID_W     = 4,
  localparam int unsigned AW = $clog2(NUM_REGS),
  localparam int unsigned SW =
    (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [ID_W-1:0]      issue_id_i,
  input  logic [AW-1:0]        issue_rd_i,
  input  logic                 issue_rd_we_i,
  input  logic [NUM_RS*AW-1:0] issue_rs_i,
  input  logic [NUM_RS-1:0]    issue_rs_use_i,
  input  logic                 commit_valid_i,
  input  logic [ID_W-1:0]      commit_id_i,
  input  logic                 commit_kill_i,
  input  logic [NUM_WB-1:0]    wb_valid_i,
  input  logic [NUM_WB*AW-1:0] wb_addr_i,
  output logic [NUM_RS-1:0]    dep_rs_o,
  output logic                 dep_rd_o,
  output logic [NUM_RS-1:0]    fwd_valid_o,
  output logic [NUM_RS*SW-1:0] fwd_sel_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned NID = 2 ** ID_W;
  localparam int unsigned DW =
    CNT_W + $clog2(NUM_WB + 1) + 1;
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic [NID-1:0]   com_q;
  logic [NID-1:0]   com_d;
  logic             err_q;
  logic             err_d;

  logic [AW-1:0]    rs   [NUM_RS];
  logic [AW-1:0]    wa   [NUM_WB];
  logic [SW-1:0]    fsel [NUM_RS];
  logic             id_ok;
  logic             fire;
  logic [DW-1:0]    sum_v;
  logic [DW-1:0]    dec_v;

  always_comb begin
    for (int i = 0; i < NUM_RS; i++)
      rs[i] = issue_rs_i[i*AW +: AW];
    for (int w = 0; w < NUM_WB; w++)
      wa[w] = wb_addr_i[w*AW +: AW];
  end

  // Forwarding only when exactly one write is pending;
  // with more, a younger write would still be outstanding.
  always_comb begin
    fwd_valid_o = '0;
    for (int i = 0; i < NUM_RS; i++)
      fsel[i] = '0;
`ifdef FPU_SS_SB_FWD_EN
    for (int i = 0; i < NUM_RS; i++) begin
      if (issue_rs_use_i[i] &&
          cnt_q[rs[i]] == CNT_W'(1)) begin
        // descending scan leaves the lowest port selected
        for (int w = NUM_WB - 1; w >= 0; w--) begin
          if (wb_valid_i[w] && wa[w] == rs[i]) begin
            fwd_valid_o[i] = 1'b1;
            fsel[i]        = SW'(w);
          end
        end
      end
    end
`endif
  end

  always_comb begin
    fwd_sel_o = '0;
    for (int i = 0; i < NUM_RS; i++)
      fwd_sel_o[i*SW +: SW] = fsel[i];
  end

  always_comb begin
    dep_rs_o = '0;
    for (int i = 0; i < NUM_RS; i++)
      dep_rs_o[i] = issue_valid_i
                  & issue_rs_use_i[i]
                  & (cnt_q[rs[i]] != '0)
                  & ~fwd_valid_o[i];
  end

  // No writeback credit: saturation is judged on cnt_q alone.
  assign dep_rd_o = issue_valid_i & issue_rd_we_i
                  & (cnt_q[issue_rd_i] == MAX);

  assign id_ok = com_q[issue_id_i]
               | (commit_valid_i & ~commit_kill_i
                  & (commit_id_i == issue_id_i));

  assign issue_ready_o = id_ok & ~(|dep_rs_o)
                       & ~dep_rd_o;

  assign fire = issue_valid_i & issue_ready_o;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    sum_v = '0;
    dec_v = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      dec_v = '0;
      for (int w = 0; w < NUM_WB; w++)
        if (wb_valid_i[w] && wa[w] == AW'(r))
          dec_v = dec_v + DW'(1);
      sum_v = DW'(cnt_q[r])
            + DW'(fire && issue_rd_we_i
                  && issue_rd_i == AW'(r));
      if (dec_v > sum_v) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(sum_v - dec_v);
      end
    end
  end

  // Issue clears after commit so a same-cycle
  // commit+fire of one ID leaves the bit at 0.
  always_comb begin
    com_d = com_q;
    if (commit_valid_i)
      com_d[commit_id_i] = ~commit_kill_i;
    if (fire)
      com_d[issue_id_i] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= '0;
      com_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= cnt_d[r];
      com_q <= com_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int r = 0; r < NUM_REGS; r++)
      busy_o = busy_o | (cnt_q[r] != '0);
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_fpu_ss_scoreboard_mp.sv
// Bench for fpu_ss_scoreboard_mp: reference model feeds an
// expectation queue, popped and compared every cycle.

module tb_fpu_ss_scoreboard_mp;

`ifdef FPU_SS_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [3:0]  issue_id_i;
  logic [4:0]  issue_rd_i;
  logic        issue_rd_we_i;
  logic [14:0] issue_rs_i;
  logic [2:0]  issue_rs_use_i;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic [1:0]  wb_valid_i;
  logic [9:0]  wb_addr_i;
  logic [2:0]  dep_rs_o;
  logic        dep_rd_o;
  logic [2:0]  fwd_valid_o;
  logic [2:0]  fwd_sel_o;
  logic        busy_o;
  logic        err_o;

  fpu_ss_scoreboard_mp dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_id_i     (issue_id_i),
    .issue_rd_i     (issue_rd_i),
    .issue_rd_we_i  (issue_rd_we_i),
    .issue_rs_i     (issue_rs_i),
    .issue_rs_use_i (issue_rs_use_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .wb_valid_i     (wb_valid_i),
    .wb_addr_i      (wb_addr_i),
    .dep_rs_o       (dep_rs_o),
    .dep_rd_o       (dep_rd_o),
    .fwd_valid_o    (fwd_valid_o),
    .fwd_sel_o      (fwd_sel_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0] dep_rs;
    logic       dep_rd;
    logic [2:0] fv;
    logic [2:0] fs;
    logic       rdy;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t       exp_q [$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         mcnt [32];
  bit         mcom [16];
  bit         merr;
  logic [4:0] rs_a [3];
  logic [4:0] wa_a [2];

  task automatic check_eq(string tag,
                          logic [31:0] act,
                          logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid_i  = 1'b0;
    issue_id_i     = '0;
    issue_rd_i     = '0;
    issue_rd_we_i  = 1'b0;
    issue_rs_use_i = '0;
    commit_valid_i = 1'b0;
    commit_id_i    = '0;
    commit_kill_i  = 1'b0;
    wb_valid_i     = '0;
    for (int i = 0; i < 3; i++) rs_a[i] = '0;
    for (int w = 0; w < 2; w++) wa_a[w] = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    for (int k = 0; k < 16; k++) mcom[k] = 1'b0;
    merr = 1'b0;
  endtask

  function automatic exp_t predict();
    exp_t e;
    bit   ok;
    int   r;
    e  = '0;
    ok = mcom[issue_id_i] ||
         (commit_valid_i && !commit_kill_i &&
          commit_id_i == issue_id_i);
    for (int i = 0; i < 3; i++) begin
      r = int'(rs_a[i]);
      if (FWD && issue_rs_use_i[i] && mcnt[r] == 1)
        for (int w = 1; w >= 0; w--)
          if (wb_valid_i[w] && wa_a[w] == rs_a[i]) begin
            e.fv[i] = 1'b1;
            e.fs[i] = w[0];
          end
      e.dep_rs[i] = issue_valid_i && issue_rs_use_i[i]
                 && mcnt[r] != 0 && !e.fv[i];
    end
    e.dep_rd = issue_valid_i && issue_rd_we_i
            && mcnt[issue_rd_i] == 3;
    e.rdy = ok && e.dep_rs == 3'b0 && !e.dep_rd;
    for (int k = 0; k < 32; k++)
      if (mcnt[k] != 0) e.busy = 1'b1;
    e.err = merr;
    return e;
  endfunction

  task automatic model_step(bit fire);
    int n;
    for (int r = 0; r < 32; r++) begin
      n = mcnt[r];
      if (fire && issue_rd_we_i && issue_rd_i == 5'(r))
        n++;
      for (int w = 0; w < 2; w++)
        if (wb_valid_i[w] && wa_a[w] == 5'(r)) n--;
      if (n < 0) begin
        n    = 0;
        merr = 1'b1;
      end
      mcnt[r] = n;
    end
    if (commit_valid_i)
      mcom[commit_id_i] = !commit_kill_i;
    if (fire)
      mcom[issue_id_i] = 1'b0;
  endtask

  task automatic cyc(string tag);
    exp_t e;
    exp_t g;
    issue_rs_i = {rs_a[2], rs_a[1], rs_a[0]};
    wb_addr_i  = {wa_a[1], wa_a[0]};
    e = predict();
    exp_q.push_back(e);
    @(negedge clk_i);
    if (exp_q.size() == 0) begin
      check_eq({tag, ".q"}, 0, 1);
    end else begin
      g = exp_q.pop_front();
      check_eq({tag, ".dep_rs"}, 32'(dep_rs_o), 32'(g.dep_rs));
      check_eq({tag, ".dep_rd"}, 32'(dep_rd_o), 32'(g.dep_rd));
      check_eq({tag, ".fwd_v"}, 32'(fwd_valid_o), 32'(g.fv));
      check_eq({tag, ".fwd_s"}, 32'(fwd_sel_o), 32'(g.fs));
      check_eq({tag, ".ready"}, 32'(issue_ready_o), 32'(g.rdy));
      check_eq({tag, ".busy"}, 32'(busy_o), 32'(g.busy));
      check_eq({tag, ".err"}, 32'(err_o), 32'(g.err));
    end
    @(posedge clk_i);
    model_step(issue_valid_i && e.rdy);
    #1;
  endtask

  task automatic issue_c(logic [3:0] id, logic [4:0] rd,
                         string tag);
    idle();
    issue_valid_i  = 1'b1;
    issue_id_i     = id;
    issue_rd_i     = rd;
    issue_rd_we_i  = 1'b1;
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    cyc(tag);
  endtask

  task automatic rand_run(int n, string tag);
    for (int c = 0; c < n; c++) begin
      idle();
      issue_valid_i  = 1'($urandom_range(0, 1));
      issue_id_i     = 4'($urandom_range(0, 15));
      issue_rd_i     = 5'($urandom_range(0, 7));
      issue_rd_we_i  = 1'($urandom_range(0, 1));
      issue_rs_use_i = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++)
        rs_a[i] = 5'($urandom_range(0, 7));
      commit_valid_i = 1'($urandom_range(0, 1));
      commit_id_i    = ($urandom_range(0, 1) == 1)
                     ? issue_id_i
                     : 4'($urandom_range(0, 15));
      commit_kill_i  = ($urandom_range(0, 3) == 0);
      for (int w = 0; w < 2; w++) begin
        wb_valid_i[w] = ($urandom_range(0, 2) == 0);
        wa_a[w]       = 5'($urandom_range(0, 7));
      end
      cyc(tag);
    end
  endtask

  initial begin
    idle();
    model_reset();
    issue_rs_i = '0;
    wb_addr_i  = '0;
    rst_ni     = 1'b0;
    #12;
    check_eq("rst.busy", 32'(busy_o), 0);
    check_eq("rst.err", 32'(err_o), 0);
    check_eq("rst.ready", 32'(issue_ready_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // commit and issue of id 3 in one cycle
    issue_c(4'd3, 5'd5, "s1");
    check_eq("s1.busy_after", 32'(busy_o), 1);

    // WAW on rd 7, then drain with port 0
    issue_c(4'd0, 5'd7, "s2a");
    issue_c(4'd1, 5'd7, "s2b");
    for (int k = 0; k < 3; k++) begin
      idle();
      issue_valid_i     = 1'b1;
      issue_id_i        = 4'd2;
      issue_rs_use_i[0] = 1'b1;
      rs_a[0]           = 5'd7;
      wb_valid_i[0]     = (k < 2);
      wa_a[0]           = 5'd7;
      cyc("s2wb");
    end

    // saturate rd 2, then 4th attempt with wb to 2
    issue_c(4'd4, 5'd2, "s3a");
    issue_c(4'd5, 5'd2, "s3b");
    issue_c(4'd6, 5'd2, "s3c");
    idle();
    issue_valid_i  = 1'b1;
    issue_id_i     = 4'd7;
    issue_rd_i     = 5'd2;
    issue_rd_we_i  = 1'b1;
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd7;
    wb_valid_i[1]  = 1'b1;
    wa_a[1]        = 5'd2;
    cyc("s3sat");

    // both ports write back to rd 4 holding one write
    issue_c(4'd8, 5'd4, "s4a");
    idle();
    issue_valid_i     = 1'b1;
    issue_id_i        = 4'd9;
    issue_rs_use_i[1] = 1'b1;
    rs_a[1]           = 5'd4;
    wb_valid_i        = 2'b11;
    wa_a[0]           = 5'd4;
    wa_a[1]           = 5'd4;
    cyc("s4fwd");
    check_eq("s4.err_after", 32'(err_o), 1);

    // kill id 6 while it waits at the head
    idle();
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd6;
    cyc("s5set");
    idle();
    issue_valid_i  = 1'b1;
    issue_id_i     = 4'd6;
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd6;
    commit_kill_i  = 1'b1;
    cyc("s5kill");
    idle();
    issue_valid_i = 1'b1;
    issue_id_i    = 4'd6;
    cyc("s5after");

    // async reset with cnt[1] = 2
    issue_c(4'd10, 5'd1, "s6a");
    issue_c(4'd11, 5'd1, "s6b");
    idle();
    check_eq("s6.busy_pre", 32'(busy_o), 1);
    check_eq("s6.err_pre", 32'(err_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("s6.busy_rst", 32'(busy_o), 0);
    check_eq("s6.err_rst", 32'(err_o), 0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    idle();
    issue_valid_i     = 1'b1;
    issue_id_i        = 4'd10;
    issue_rs_use_i[0] = 1'b1;
    rs_a[0]           = 5'd1;
    cyc("s6post");

    rand_run(200, "rnd");

    check_eq("q.left", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
